// File: rtl/ysyx_23060171_mc_core.sv
// Multi-cycle RV32 integer core: a FETCH/EXEC sequencer over a valid/ready instruction port.
// Optional commit trace ports are enabled by defining YSYX_23060171_COMMIT_TRACE_EN.
//
// state   | meaning
// FETCH   | request imem at pc, wait for ready (optional timeout)
// EXEC    | decode, write rd, update pc
// HALT    | ebreak seen, absorbing until reset
// TRAP    | illegal/misaligned/timeout, absorbing until reset
module ysyx_23060171_mc_core #(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          NR_REGS       = 16,
  parameter int          FETCH_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] halt_code,
  output logic        trap
`ifdef YSYX_23060171_COMMIT_TRACE_EN
  ,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_wdata
`endif
);

  localparam int          AW     = $clog2(NR_REGS);
  localparam logic [5:0]  NR     = 6'(NR_REGS);
  localparam logic [31:0] TO     = 32'(FETCH_TIMEOUT);
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT, S_TRAP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] inst;
  logic [31:0] to_cnt, cnt_nxt;
  logic [31:0] regs [NR_REGS];
  logic        rf_we, halt_we;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        rd_ok, rs1_ok, rs2_ok;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_j, imm_u, jtgt;
  logic        exec_ok, exec_brk, exec_wen;
  logic [31:0] exec_wdata, exec_pc;

  assign imem_valid = (state == S_FETCH) && rst;
  assign imem_addr  = pc;
  assign halted     = (state == S_HALT);
  assign trap       = (state == S_TRAP);

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  assign rd_ok  = {1'b0, rd}  < NR;
  assign rs1_ok = {1'b0, rs1} < NR;
  assign rs2_ok = {1'b0, rs2} < NR;
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u  = {inst[31:12], 12'h000};

  always_comb begin
    rs1_val    = '0;
    rs2_val    = '0;
    jtgt       = '0;
    exec_ok    = 1'b0;
    exec_brk   = 1'b0;
    exec_wdata = '0;
    exec_pc    = pc + 32'd4;
    if (rs1 != 5'd0 && rs1_ok) rs1_val = regs[rs1[AW-1:0]];
    if (rs2 != 5'd0 && rs2_ok) rs2_val = regs[rs2[AW-1:0]];
    case (opcode)
      OP_LUI: begin
        exec_ok    = rd_ok;
        exec_wdata = imm_u;
      end
      OP_AUIPC: begin
        exec_ok    = rd_ok;
        exec_wdata = pc + imm_u;
      end
      OP_IMM: begin
        exec_ok    = rd_ok && rs1_ok && (f3 == 3'd0);
        exec_wdata = rs1_val + imm_i;
      end
      OP_REG: begin
        exec_ok    = rd_ok && rs1_ok && rs2_ok && (f3 == 3'd0) &&
                     (f7 == 7'h00 || f7 == 7'h20);
        exec_wdata = f7[5] ? rs1_val - rs2_val : rs1_val + rs2_val;
      end
      OP_JAL: begin
        jtgt       = pc + imm_j;
        exec_ok    = rd_ok && !jtgt[1];
        exec_wdata = pc + 32'd4;
        exec_pc    = jtgt;
      end
      OP_JALR: begin
        jtgt       = (rs1_val + imm_i) & ~32'd1;
        exec_ok    = rd_ok && rs1_ok && (f3 == 3'd0) && !jtgt[1];
        exec_wdata = pc + 32'd4;
        exec_pc    = jtgt;
      end
      default: exec_brk = (inst == EBREAK);
    endcase
    exec_wen = exec_ok && (rd != 5'd0);
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = to_cnt;
    rf_we     = 1'b0;
    halt_we   = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          state_nxt = S_EXEC;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = to_cnt + 32'd1;
          if (FETCH_TIMEOUT != 0 && cnt_nxt == TO) state_nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        if (exec_brk) begin
          state_nxt = S_HALT;
          halt_we   = 1'b1;
        end else if (exec_ok) begin
          state_nxt = S_FETCH;
          pc_nxt    = exec_pc;
          rf_we     = exec_wen;
        end else begin
          state_nxt = S_TRAP;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      inst      <= '0;
      to_cnt    <= '0;
      halt_code <= '0;
      for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      to_cnt <= cnt_nxt;
      if (state == S_FETCH && imem_ready) inst <= imem_rdata;
      if (rf_we) regs[rd[AW-1:0]] <= exec_wdata;
      if (halt_we) halt_code <= regs[AW'(10)];
    end
  end

`ifdef YSYX_23060171_COMMIT_TRACE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_rd    <= '0;
      commit_wdata <= '0;
    end else begin
      commit_valid <= (state == S_EXEC) && (exec_ok || exec_brk);
      if (state == S_EXEC && (exec_ok || exec_brk)) begin
        commit_pc    <= pc;
        commit_inst  <= inst;
        commit_rd    <= exec_wen ? rd : 5'd0;
        commit_wdata <= exec_wen ? exec_wdata : 32'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060171_mc_core.sv
// Scoreboarded bench for the multi-cycle core: an ISA-level model predicts the fetch
// address stream and final halt/trap status; a monitor checks every fetch handshake.
module tb_ysyx_23060171_mc_core;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int NRR = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_valid, imem_ready, halted, trap;
  logic [31:0] imem_addr, imem_rdata, pc, halt_code;
  logic        to_valid, to_halted, to_trap;
  logic [31:0] to_addr, to_pc, to_code;
  logic        to_ready = 1'b0;
  logic [31:0] to_rdata = 32'h0;

  always #5 clk = ~clk;

  ysyx_23060171_mc_core #(.RESET_PC(RESET_PC), .NR_REGS(NRR), .FETCH_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .halted(halted),
    .halt_code(halt_code), .trap(trap));

  ysyx_23060171_mc_core #(.RESET_PC(RESET_PC), .NR_REGS(NRR), .FETCH_TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .imem_valid(to_valid), .imem_addr(to_addr),
    .imem_ready(to_ready), .imem_rdata(to_rdata), .pc(to_pc), .halted(to_halted),
    .halt_code(to_code), .trap(to_trap));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 3;
  int hold_cnt = 0;
  logic [31:0] mem [64];
  logic [31:0] exp_q [$];
  int hs_cyc [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - RESET_PC;
    if (off < 32'd256 && off[1:0] == 2'b00) return mem[off[7:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] e_i(input int imm, input int rs1, input int f3, input int rd,
                                      input logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] e_r(input int f7, input int rs2, input int rs1, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] e_u(input int imm, input int rd, input logic [6:0] op);
    return {20'(imm), 5'(rd), op};
  endfunction
  function automatic logic [31:0] e_j(input int off, input int rd);
    logic [20:0] o;
    o = 21'(off);
    return {o[20], o[10:1], o[11], o[19:12], 5'(rd), 7'h6f};
  endfunction

  // ISA reference: 0 = continue, 1 = halt, 2 = trap
  function automatic int model_step(input logic [31:0] ins);
    int rd, rs1, rs2, f3, f7;
    logic [31:0] a, b, ii, ij, uu, t, res;
    rd  = int'(ins[11:7]);
    rs1 = int'(ins[19:15]);
    rs2 = int'(ins[24:20]);
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    ii  = {{20{ins[31]}}, ins[31:20]};
    ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    uu  = {ins[31:12], 12'h000};
    res = 32'h0;
    if (ins == 32'h0010_0073) return 1;
    if (rd >= NRR) return 2;
    case (ins[6:0])
      7'h37: res = uu;
      7'h17: res = m_pc + uu;
      7'h13: begin
        if (f3 != 0 || rs1 >= NRR) return 2;
        res = a + ii;
      end
      7'h33: begin
        if (f3 != 0 || rs1 >= NRR || rs2 >= NRR) return 2;
        if (f7 == 0) res = a + b;
        else if (f7 == 32) res = a - b;
        else return 2;
      end
      7'h6f, 7'h67: begin
        if (ins[6:0] == 7'h6f) t = m_pc + ij;
        else begin
          if (f3 != 0 || rs1 >= NRR) return 2;
          t = (a + ii) & ~32'd1;
        end
        if (t[1]) return 2;
        if (rd != 0) m_regs[rd] = m_pc + 32'd4;
        m_pc = t;
        return 0;
      end
      default: return 2;
    endcase
    if (rd != 0) m_regs[rd] = res;
    m_pc = m_pc + 32'd4;
    return 0;
  endfunction

  always @(negedge clk) cyc++;

  // instruction memory driver: ready pattern by mode, rdata looked up at the request address
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: imem_ready = 1'b1;
        1: imem_ready = 1'($urandom_range(0, 1));
        2: imem_ready = (hold_cnt >= 7);
        default: imem_ready = 1'b0;
      endcase
      if (rdy_mode == 2 && rst && imem_valid) hold_cnt++;
      imem_rdata = mem_lookup(imem_addr);
    end
  end

  // monitor: pops the expected fetch address on every handshake, checks request stability
  initial begin
    logic prev_wait;
    logic [31:0] prev_addr, e;
    prev_wait = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_wait) begin
          chk("fetch_hold_valid", {31'h0, imem_valid}, 32'h1);
          chk("fetch_hold_addr", imem_addr, prev_addr);
        end
        if (imem_valid && imem_ready) begin
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
          end else begin
            e = exp_q.pop_front();
            chk("fetch_addr", imem_addr, e);
          end
        end
        prev_wait = imem_valid && !imem_ready;
        prev_addr = imem_addr;
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_rst_valid"}, {31'h0, imem_valid}, 32'h0);
    chk({tag, "_rst_pc"}, pc, RESET_PC);
    chk({tag, "_rst_halted"}, {31'h0, halted}, 32'h0);
    chk({tag, "_rst_trap"}, {31'h0, trap}, 32'h0);
    chk({tag, "_rst_code"}, halt_code, 32'h0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic run_episode(input int mode, input string tag);
    int n, status, steps;
    logic exp_halt, exp_trap;
    logic [31:0] exp_code;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pc = RESET_PC;
    status = 0;
    steps = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1 reset_checks(tag);
    exp_q.delete();
    hs_cyc.delete();
    while (status == 0 && steps < 64) begin
      exp_q.push_back(m_pc);
      status = model_step(mem_lookup(m_pc));
      steps++;
    end
    exp_halt = (status == 1);
    exp_trap = (status == 2);
    exp_code = exp_halt ? m_regs[10] : 32'h0;
    rdy_mode = mode;
    hold_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    while (!(halted || trap) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_finished"}, {31'h0, halted | trap}, 32'h1);
    chk({tag, "_fetches_left"}, 32'(exp_q.size()), 32'h0);
    chk({tag, "_halted"}, {31'h0, halted}, {31'h0, exp_halt});
    chk({tag, "_trap"}, {31'h0, trap}, {31'h0, exp_trap});
    chk({tag, "_halt_code"}, halt_code, exp_code);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_valid_idle"}, {31'h0, imem_valid}, 32'h0);
  endtask

  task automatic gen_random_prog();
    int r;
    clear_mem();
    for (int s = 0; s < 12; s++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      mem[s] = e_i($urandom_range(0, 4095), $urandom_range(0, 15), 0,
                                      $urandom_range(0, 15), 7'h13);
      else if (r < 55) mem[s] = e_r(($urandom_range(0, 1) != 0) ? 32 : 0, $urandom_range(0, 15),
                                      $urandom_range(0, 15), $urandom_range(0, 15));
      else if (r < 68) mem[s] = e_u($urandom, $urandom_range(0, 15), 7'h37);
      else if (r < 78) mem[s] = e_u($urandom, $urandom_range(0, 15), 7'h17);
      else if (r < 86) mem[s] = e_j(4 * $urandom_range(1, 3), $urandom_range(0, 15));
      else if (r < 88) mem[s] = e_j(6, 1);
      else if (r < 89) mem[s] = e_r(1, 2, 3, 4);
      else if (r < 90) mem[s] = e_i(1, 0, 0, 17, 7'h13);
      else             mem[s] = e_i($urandom_range(0, 4095), $urandom_range(0, 15), 0,
                                      $urandom_range(1, 15), 7'h13);
    end
    mem[12] = e_r(0, 0, $urandom_range(0, 15), 10);
    mem[13] = 32'h0010_0073;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset_checks("por");
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("to_wait_trap", {31'h0, to_trap}, 32'h0);
      chk("to_wait_valid", {31'h0, to_valid}, 32'h1);
    end
    @(negedge clk);
    chk("to_trap", {31'h0, to_trap}, 32'h1);
    chk("to_valid_off", {31'h0, to_valid}, 32'h0);
    chk("to_pc", to_pc, RESET_PC);

    clear_mem();
    mem[0] = e_i(5, 0, 0, 1, 7'h13);
    mem[1] = e_i(-7, 1, 0, 1, 7'h13);
    mem[2] = e_r(0, 0, 1, 10);
    mem[3] = 32'h0010_0073;
    run_episode(0, "addi");
    chk("addi_code_const", halt_code, 32'hFFFF_FFFE);
    chk("addi_nfetch", 32'(hs_cyc.size()), 32'd4);
    for (int i = 1; i < hs_cyc.size(); i++) chk("cpi", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);

    run_episode(2, "stall");
    chk("stall_code_const", halt_code, 32'hFFFF_FFFE);

    clear_mem();
    mem[0] = e_u(32'h80000, 2, 7'h37);
    mem[1] = e_i(32'h11, 2, 0, 2, 7'h13);
    mem[2] = e_i(3, 2, 0, 5, 7'h67);
    mem[5] = e_r(0, 0, 5, 10);
    mem[6] = 32'h0010_0073;
    run_episode(1, "jalr");
    chk("jalr_link_const", halt_code, 32'h8000_000C);

    clear_mem();
    mem[0] = e_j(2, 1);
    run_episode(1, "jal_mis");
    chk("jal_mis_pc_const", pc, RESET_PC);

    clear_mem();
    mem[0] = e_i(7, 0, 0, 3, 7'h13);
    mem[1] = e_i(-1, 3, 0, 1, 7'h67);
    run_episode(1, "jalr_mis");

    clear_mem();
    mem[0] = e_u(32'hABCDE, 10, 7'h37);
    mem[1] = 32'h0010_0073;
    run_episode(0, "ebreak");
    chk("ebreak_code_const", halt_code, 32'hABCD_E000);

    clear_mem();
    mem[0] = e_i(1, 0, 0, 17, 7'h13);
    run_episode(1, "badreg");
    chk("badreg_trap_const", {31'h0, trap}, 32'h1);

    for (int e = 0; e < 30; e++) begin
      gen_random_prog();
      run_episode((e % 3 == 0) ? 0 : 1, "rand");
    end

    // reset asserted while waiting in FETCH
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    rdy_mode = 3;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midfetch_valid_before", {31'h0, imem_valid}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 reset_checks("midfetch");

    // reset asserted during EXEC
    clear_mem();
    mem[0] = e_i(5, 0, 0, 10, 7'h13);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    rdy_mode = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_valid && imem_ready) && n < 50);
    chk("midexec_handshake", {31'h0, imem_valid & imem_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 reset_checks("midexec");
    chk("midexec_fetches_left", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached with %0d failures", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
